// File: rtl/ps2_pkg.sv
// Shared PS/2 device-port definitions: FSM states, frame sizes and frame helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITBUS = 3'd1,
        TXBIT   = 3'd2,
        RXBIT   = 3'd3,
        RXACK   = 3'd4,
        HOLDOFF = 3'd5
    } ps2_state_t;

    localparam int TX_SLOTS = 11;   // start, 8 data, parity, stop
    localparam int RX_SLOTS = 10;   // 8 data, parity, stop (start is the request itself)

    localparam logic [3:0] TX_LAST_SLOT = 4'(TX_SLOTS - 1);
    localparam logic [3:0] RX_LAST_SLOT = 4'(RX_SLOTS - 1);

    // Level to place on the data line during a given device-to-host slot.
    function automatic logic tx_frame_bit(input logic [7:0] data, input logic [3:0] slot);
        logic [2:0] idx;
        logic       bit_val;
        idx = slot[2:0] - 3'd1;
        if (slot == 4'd0)
            bit_val = 1'b0;
        else if (slot <= 4'd8)
            bit_val = data[idx];
        else if (slot == 4'd9)
            bit_val = ~^data;
        else
            bit_val = 1'b1;
        return bit_val;
    endfunction

    // Host frame {stop, parity, d7..d0} is good when parity is odd and stop is high.
    function automatic logic rx_frame_ok(input logic [9:0] bits);
        return bits[9] & (^bits[8:0]);
    endfunction

endpackage

// File: rtl/ps2_device_port_sync2.sv
// Two-flop synchronizer for one PS/2 line; resets to the idle (high) level.
module ps2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous line and re-register it once to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_device_port.sv
// PS/2 device-side port: sends bytes to the host and receives host commands with ack.
module ps2_device_port
    import ps2_pkg::*;
#(
    parameter int HALFPER  = 1120,
    parameter int IDLEWAIT = 1400
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2clk_ext,
    inout  wire        ps2data_ext,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int CNT_TOP = (2 * HALFPER > IDLEWAIT) ? 2 * HALFPER : IDLEWAIT;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALFPER - 1);
    localparam logic [CW-1:0] HALF_START = CW'(HALFPER);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(2 * HALFPER - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLEWAIT - 1);

    ps2_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    slot, slot_nxt;
    logic [9:0]    rx_bits, rx_bits_nxt;
    logic [7:0]    tx_byte;
    logic [7:0]    rx_data_nxt;
    logic          busy_nxt, done_nxt, abort_nxt, valid_nxt, error_nxt;
    logic          clk_low, clk_low_nxt, data_low, data_low_nxt;
    logic          clk_s, data_s, host_rts;

    ps2_sync2 u_sync_clk  (.clk(clk), .rst(rst), .d(ps2clk_ext),  .q(clk_s));
    ps2_sync2 u_sync_data (.clk(clk), .rst(rst), .d(ps2data_ext), .q(data_s));

    // Open-drain drivers: only ever pull low or float.
    assign ps2clk_ext  = clk_low  ? 1'b0 : 1'bz;
    assign ps2data_ext = data_low ? 1'b0 : 1'bz;

    assign host_rts = clk_s & ~data_s;

    // Next-state, counter, pulse and line-drive logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt   = state;
        cnt_nxt     = cnt;
        slot_nxt    = slot;
        rx_bits_nxt = rx_bits;
        rx_data_nxt = rx_data;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        valid_nxt   = 1'b0;
        error_nxt   = 1'b0;

        if (tx_load && !tx_busy)
            busy_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (host_rts) begin
                    state_nxt = RXBIT;
                    cnt_nxt   = '0;
                    slot_nxt  = '0;
                end else if (tx_busy) begin
                    state_nxt = WAITBUS;
                    cnt_nxt   = '0;
                end
            end
            WAITBUS: begin
                if (host_rts) begin
                    state_nxt = RXBIT;
                    cnt_nxt   = '0;
                    slot_nxt  = '0;
                end else if (clk_s && data_s) begin
                    if (cnt == IDLE_LAST) begin
                        state_nxt = TXBIT;
                        cnt_nxt   = '0;
                        slot_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            TXBIT: begin
                if (cnt == HALF_LAST && !clk_s && slot != TX_LAST_SLOT) begin
                    // Host inhibit: drop the frame but keep the byte pending.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    slot_nxt  = '0;
                    abort_nxt = 1'b1;
                end else if (cnt == SLOT_LAST) begin
                    cnt_nxt = '0;
                    if (slot == TX_LAST_SLOT) begin
                        state_nxt = HOLDOFF;
                        slot_nxt  = '0;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        slot_nxt = slot + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RXBIT: begin
                if (cnt == SLOT_LAST) begin
                    rx_bits_nxt[slot] = data_s;
                    cnt_nxt           = '0;
                    if (slot == RX_LAST_SLOT) begin
                        state_nxt = RXACK;
                        slot_nxt  = '0;
                    end else begin
                        slot_nxt = slot + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RXACK: begin
                if (cnt == SLOT_LAST) begin
                    // Holdoff also masks the synchronizers still showing our own ack low.
                    state_nxt = HOLDOFF;
                    cnt_nxt   = '0;
                    if (rx_frame_ok(rx_bits)) begin
                        rx_data_nxt = rx_bits[7:0];
                        valid_nxt   = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == SLOT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                slot_nxt  = '0;
            end
        endcase

        // Line drives follow the state being entered so they stay aligned with it.
        clk_low_nxt  = 1'b0;
        data_low_nxt = 1'b0;
        case (state_nxt)
            TXBIT: begin
                clk_low_nxt  = (cnt_nxt >= HALF_START);
                data_low_nxt = ~tx_frame_bit(tx_byte, slot_nxt);
            end
            RXBIT: clk_low_nxt = (cnt_nxt < HALF_START);
            RXACK: begin
                clk_low_nxt  = (cnt_nxt < HALF_START);
                data_low_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters, captured bytes and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            slot     <= '0;
            rx_bits  <= '0;
            tx_byte  <= '0;
            rx_data  <= 8'h00;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            slot     <= slot_nxt;
            rx_bits  <= rx_bits_nxt;
            rx_data  <= rx_data_nxt;
            tx_busy  <= busy_nxt;
            tx_done  <= done_nxt;
            tx_abort <= abort_nxt;
            rx_valid <= valid_nxt;
            rx_error <= error_nxt;
            clk_low  <= clk_low_nxt;
            data_low <= data_low_nxt;
            if (tx_load && !tx_busy)
                tx_byte <= tx_data;
        end
    end

endmodule

// File: tb/tb_ps2_device_port.sv
// Self-checking bench for ps2_device_port with a behavioural PS/2 host model.
module tb_ps2_device_port;

    localparam int HALFPER  = 8;
    localparam int IDLEWAIT = 10;
    localparam int BUDGET   = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_busy, tx_done, tx_abort, rx_valid, rx_error;
    logic [7:0] rx_data;

    logic host_clk_low  = 1'b0;
    logic host_data_low = 1'b0;
    wire  ps2clk, ps2data;

    assign ps2clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2data = host_data_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    ps2_device_port #(.HALFPER(HALFPER), .IDLEWAIT(IDLEWAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2clk_ext (ps2clk),
        .ps2data_ext(ps2data),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0, abort_cnt = 0, valid_cnt = 0, error_cnt = 0, multi_cnt = 0;
    logic [7:0] model_rx = 8'h00;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        done_cnt  = done_cnt  + int'(tx_done);
        abort_cnt = abort_cnt + int'(tx_abort);
        valid_cnt = valid_cnt + int'(rx_valid);
        error_cnt = error_cnt + int'(rx_error);
        if (int'(tx_done) + int'(tx_abort) + int'(rx_valid) + int'(rx_error) > 1)
            multi_cnt = multi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected device-to-host frame, slot 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input logic level_after, output bit timed_out);
        logic prev;
        timed_out = 1'b0;
        prev = ps2clk;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (prev == ~level_after && ps2clk == level_after) return;
            prev = ps2clk;
        end
        timed_out = 1'b1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Host side of a device-to-host frame: sample data on each clk fall.
    task automatic recv_and_check(input string tag, input logic [7:0] b);
        logic [10:0] fr;
        bit          to;
        int          d0;
        d0 = done_cnt;
        fr = '0;
        for (int i = 0; i < 11; i++) begin
            wait_edge(1'b0, to);
            if (to) begin
                check({tag, "_timeout"}, 32'd1, 32'd0);
                return;
            end
            fr[i] = ps2data;
        end
        cycles(2 * HALFPER + 4);
        check({tag, "_frame"}, 32'(fr), 32'(frame_model(b)));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy"}, 32'(tx_busy), 32'd0);
    endtask

    // Host-to-device frame: request, bits on clk falls, then verify the ack slot.
    task automatic host_send(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [9:0] bits;
        bit         to, good;
        logic       ack_ok;
        int         v0, e0;
        bits[7:0] = b;
        bits[8]   = ($countones(b) % 2 == 0) ^ bad_par;
        bits[9]   = ~bad_stop;
        good      = !bad_par && !bad_stop;
        v0 = valid_cnt;
        e0 = error_cnt;
        host_data_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_edge(1'b0, to);
            if (to) begin
                host_data_low = 1'b0;
                check({tag, "_timeout"}, 32'd1, 32'd0);
                return;
            end
            host_data_low = ~bits[i];
        end
        wait_edge(1'b0, to);
        host_data_low = 1'b0;
        if (to) begin
            check({tag, "_ack_timeout"}, 32'd1, 32'd0);
            return;
        end
        ack_ok = 1'b1;
        for (int k = 0; k < 2 * HALFPER - 1; k++) begin
            ack_ok &= (ps2data == 1'b0);
            @(negedge clk);
        end
        cycles(6);
        if (good) model_rx = b;
        check({tag, "_ack"}, 32'(ack_ok), 32'd1);
        check({tag, "_valid"}, 32'(valid_cnt - v0), good ? 32'd1 : 32'd0);
        check({tag, "_error"}, 32'(error_cnt - e0), good ? 32'd0 : 32'd1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(model_rx));
        cycles(2 * HALFPER + 4);
    endtask

    initial begin
        bit         to;
        int         a0, d0;
        logic [7:0] rb;

        // Reset state
        rst = 1'b1;
        cycles(3);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_abort", 32'(tx_abort), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_clk_line", 32'(ps2clk), 32'd1);
        check("rst_data_line", 32'(ps2data), 32'd1);
        rst = 1'b0;
        cycles(5);

        // Basic transmit; a load while busy must be ignored
        load_byte(8'h1C);
        cycles(1);
        check("busy_after_load", 32'(tx_busy), 32'd1);
        load_byte(8'h55);
        recv_and_check("tx_1c", 8'h1C);

        // Host inhibit in slot 4, then full resend
        load_byte(8'hAA);
        a0 = abort_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) wait_edge(1'b0, to);
        wait_edge(1'b1, to);
        check("abort_wait_timeout", 32'(to), 32'd0);
        host_clk_low = 1'b1;
        cycles(20);
        check("abort_pulse", 32'(abort_cnt - a0), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd1);
        check("abort_data_line", 32'(ps2data), 32'd1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        host_clk_low = 1'b0;
        recv_and_check("tx_aa_resend", 8'hAA);

        // Host commands: good frame, then wrong parity
        host_send("rx_ff", 8'hFF, 1'b0, 1'b0);
        host_send("rx_ed_badpar", 8'hED, 1'b1, 1'b0);

        // Request coinciding with a load: receive first, then transmit
        rb = 8'($urandom);
        tx_data = 8'h3C;
        tx_load = 1'b1;
        host_data_low = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        host_send("rx_coinc", rb, 1'b0, 1'b0);
        check("coinc_busy_pending", 32'(tx_busy), 32'd1);
        recv_and_check("tx_after_rx", 8'h3C);

        // Randomized traffic in both directions
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            load_byte(rb);
            recv_and_check($sformatf("rand_tx%0d", n), rb);
            host_send($sformatf("rand_rx%0d", n), 8'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset during slot 6 while both lines are driven low
        load_byte(8'h00);
        d0 = done_cnt;
        for (int i = 0; i < 7; i++) wait_edge(1'b0, to);
        check("rst_mid_wait_timeout", 32'(to), 32'd0);
        cycles(2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_clk_line", 32'(ps2clk), 32'd1);
        check("rst_mid_data_line", 32'(ps2data), 32'd1);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        cycles(300);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_idle_clk", 32'(ps2clk), 32'd1);

        check("pulse_exclusive", 32'(multi_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
